// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank
//   Responder end of the FIR coefficient-reload interface. Sixteen
//   coefficients live in a double-buffered store. The shadow bank is
//   written and read over the reload port. The active bank drives the FIR
//   core flat. A complete shadow load is copied to the active bank in one
//   edge, and the copy waits while the core holds swap_hold.
//
//   Optional build macro: COEFF_READ_ACTIVE_EN. When it is defined, reads
//   return the active bank instead of the shadow bank.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   coeff_in_areset  synchronous clear of shadow, read valids, pending commit
//   coeff_in_we      per-lane write enable (4 lanes)
//   coeff_in_adr     word address (coefficient n = 4*adr + lane)
//   coeff_in_data    write data, lane k = bits [16k+15:16k]
//   coeff_in_read    read request at coeff_in_adr
//   coeff_out_valid  per-lane read valid, READ_LAT cycles after the request
//   coeff_out_data   read data; holds its last value while valid is low
//   swap_hold        core busy, defer commit
//   swap_done        one-cycle pulse on the edge the active bank updates
//   commit_pending   a commit is armed and waiting
//   coeffs_active    active bank, coefficient n = bits [16n+15:16n]
module fir_coeff_bank #(
    parameter int COEFF_W  = 16,
    parameter int READ_LAT = 2,
    parameter int LAST_ADR = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  coeff_in_areset,
    input  logic [3:0]            coeff_in_we,
    input  logic [1:0]            coeff_in_adr,
    input  logic [4*COEFF_W-1:0]  coeff_in_data,
    input  logic                  coeff_in_read,
    output logic [3:0]            coeff_out_valid,
    output logic [4*COEFF_W-1:0]  coeff_out_data,
    input  logic                  swap_hold,
    output logic                  swap_done,
    output logic                  commit_pending,
    output logic [16*COEFF_W-1:0] coeffs_active
);

    localparam int NUM_LANES = 4;
    localparam int NUM_WORDS = 4;

    // [word][lane][bit]: the packed layout matches the flat coefficient order.
    logic [NUM_WORDS-1:0][NUM_LANES-1:0][COEFF_W-1:0] shadow;
    logic [NUM_WORDS-1:0][NUM_LANES-1:0][COEFF_W-1:0] active;

    logic [NUM_LANES*COEFF_W-1:0]                rd_src;
    logic [READ_LAT-1:0]                         vld_pipe;
    logic [READ_LAT-1:0][NUM_LANES*COEFF_W-1:0]  dat_pipe;
    logic                                        arm;
    logic                                        do_swap;

    // ---------------------------------------------------------------- shadow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (coeff_in_areset) begin
            shadow <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (coeff_in_we[l])
                    shadow[coeff_in_adr][l] <= coeff_in_data[l*COEFF_W +: COEFF_W];
            end
        end
    end

    // ------------------------------------------------------------ read path
    // The source word is captured on the request edge, so a write to the
    // same address on that edge is not seen (read-before-write).
`ifdef COEFF_READ_ACTIVE_EN
    assign rd_src = active[coeff_in_adr];
`else
    assign rd_src = shadow[coeff_in_adr];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else if (coeff_in_areset) begin
            // Data stages are left alone so the output data keeps its value.
            vld_pipe <= '0;
        end else begin
            vld_pipe <= READ_LAT'({vld_pipe, coeff_in_read});
            // Stages load only behind a valid, so the last stage holds between results.
            for (int s = READ_LAT - 1; s >= 1; s--) begin
                if (vld_pipe[s-1])
                    dat_pipe[s] <= dat_pipe[s-1];
            end
            if (coeff_in_read)
                dat_pipe[0] <= rd_src;
        end
    end

    assign coeff_out_valid = {NUM_LANES{vld_pipe[READ_LAT-1]}};
    assign coeff_out_data  = dat_pipe[READ_LAT-1];

    // --------------------------------------------------------------- commit
    assign arm = !coeff_in_areset && coeff_in_we[NUM_LANES-1]
                 && (coeff_in_adr == 2'(LAST_ADR));

    // An arming write on the same edge defers the swap by one edge. The
    // copy then includes that write, and only one swap_done is produced.
    assign do_swap = commit_pending && !swap_hold && !arm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active         <= '0;
            commit_pending <= 1'b0;
            swap_done      <= 1'b0;
        end else begin
            swap_done <= do_swap;
            if (do_swap)
                active <= shadow;
            if (coeff_in_areset)
                commit_pending <= 1'b0;
            else if (arm)
                commit_pending <= 1'b1;
            else if (do_swap)
                commit_pending <= 1'b0;
        end
    end

    assign coeffs_active = active;

endmodule

// File: tb/tb_fir_coeff_bank.sv
module tb_fir_coeff_bank;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         coeff_in_areset = 1'b0;
    logic [3:0]   coeff_in_we = '0;
    logic [1:0]   coeff_in_adr = '0;
    logic [63:0]  coeff_in_data = '0;
    logic         coeff_in_read = 1'b0;
    logic         swap_hold = 1'b0;
    logic [3:0]   coeff_out_valid;
    logic [63:0]  coeff_out_data;
    logic         swap_done;
    logic         commit_pending;
    logic [255:0] coeffs_active;

    fir_coeff_bank #(.COEFF_W(16), .READ_LAT(LAT), .LAST_ADR(3)) dut (
        .clk(clk), .reset_n(reset_n), .coeff_in_areset(coeff_in_areset),
        .coeff_in_we(coeff_in_we), .coeff_in_adr(coeff_in_adr),
        .coeff_in_data(coeff_in_data), .coeff_in_read(coeff_in_read),
        .coeff_out_valid(coeff_out_valid), .coeff_out_data(coeff_out_data),
        .swap_hold(swap_hold), .swap_done(swap_done),
        .commit_pending(commit_pending), .coeffs_active(coeffs_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [15:0] msh [16];
    logic [15:0] mact [16];
    logic [63:0] exp_q [$];
    int          exp_cyc [$];

    function automatic logic [63:0] model_row(input logic [1:0] adr);
        logic [63:0] r;
        for (int k = 0; k < 4; k++) begin
`ifdef COEFF_READ_ACTIVE_EN
            r[16*k +: 16] = mact[4*adr + k];
`else
            r[16*k +: 16] = msh[4*adr + k];
`endif
        end
        return r;
    endfunction

    // Scoreboard monitor: every valid pulse must match the oldest queued read.
    always @(negedge clk) begin
        if (reset_n && coeff_out_valid !== 4'h0) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: got valid=%h data=%h, required no valid",
                         coeff_out_valid, coeff_out_data);
            end else begin
                logic [63:0] e;
                int          c;
                e = exp_q.pop_front();
                c = exp_cyc.pop_front();
                if (coeff_out_valid !== 4'hF || coeff_out_data !== e || cyc != c) begin
                    fails++;
                    $display("FAIL read_data: got valid=%h data=%h cyc=%0d, required valid=f data=%h cyc=%0d",
                             coeff_out_valid, coeff_out_data, cyc, e, c);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] we, input logic [1:0] adr,
                         input logic [63:0] d, input logic rd, input logic push);
        coeff_in_we   = we;
        coeff_in_adr  = adr;
        coeff_in_data = d;
        coeff_in_read = rd;
        if (rd && push) begin
            exp_q.push_back(model_row(adr));
            exp_cyc.push_back(cyc + LAT);
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++)
            if (we[k]) msh[4*adr + k] = d[16*k +: 16];
        #1;
        coeff_in_we   = '0;
        coeff_in_read = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (LAT + 2) step();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d reads never returned, required 0", name, exp_q.size());
            exp_q.delete();
            exp_cyc.delete();
        end
    endtask

    task automatic check_active(input string name);
        logic [255:0] e;
        for (int n = 0; n < 16; n++) e[16*n +: 16] = mact[n];
        tests++;
        if (coeffs_active !== e) begin
            fails++;
            $display("FAIL %s: got active=%h, required %h", name, coeffs_active, e);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic model_clear(input logic both);
        for (int n = 0; n < 16; n++) begin
            msh[n] = '0;
            if (both) mact[n] = '0;
        end
    endtask

    task automatic test_reset();
        model_clear(1'b1);
        reset_n = 1'b0;
        repeat (2) step();
        tests++;
        if (coeff_out_valid !== 4'h0 || coeff_out_data !== 64'h0) begin
            fails++;
            $display("FAIL reset_out: got valid=%h data=%h, required 0/0", coeff_out_valid, coeff_out_data);
        end
        check_bit("reset_done", swap_done, 1'b0);
        check_bit("reset_pending", commit_pending, 1'b0);
        check_active("reset_active");
        reset_n = 1'b1;
        step();
        for (int a = 0; a < 4; a++) drive(4'h0, 2'(a), 64'h0, 1'b1, 1'b1);
        drain("reset_reads");
    endtask

    task automatic test_commit();
        logic [63:0] d;
        for (int a = 0; a < 4; a++) begin
            for (int k = 0; k < 4; k++) d[16*k +: 16] = 16'(4*a + k + 1);
            drive(4'hF, 2'(a), d, 1'b0, 1'b0);
        end
        check_bit("commit_armed", commit_pending, 1'b1);
        check_bit("commit_no_early_done", swap_done, 1'b0);
        step();
        check_bit("commit_done", swap_done, 1'b1);
        check_bit("commit_cleared", commit_pending, 1'b0);
        for (int n = 0; n < 16; n++) mact[n] = msh[n];
        check_active("commit_active");
        tests++;
        if (coeffs_active[15:0] !== 16'd1 || coeffs_active[255:240] !== 16'd16) begin
            fails++;
            $display("FAIL commit_ends: got c0=%h c15=%h, required 0001/0010",
                     coeffs_active[15:0], coeffs_active[255:240]);
        end
        step();
        check_bit("commit_done_pulse", swap_done, 1'b0);
        for (int a = 0; a < 4; a++) drive(4'h0, 2'(a), 64'h0, 1'b1, 1'b1);
        drain("commit_reads");
    endtask

    task automatic test_hold();
        swap_hold = 1'b1;
        for (int a = 0; a < 4; a++) drive(4'hF, 2'(a), {4{16'h00FF}}, 1'b0, 1'b0);
        repeat (10) step();
        check_bit("hold_pending", commit_pending, 1'b1);
        check_bit("hold_no_done", swap_done, 1'b0);
        check_active("hold_frozen");
        swap_hold = 1'b0;
        step();
        check_bit("hold_release_done", swap_done, 1'b1);
        for (int n = 0; n < 16; n++) mact[n] = msh[n];
        check_active("hold_release_active");
        step();
        check_bit("hold_done_pulse", swap_done, 1'b0);
    endtask

    task automatic test_partial_rbw();
        drive(4'b0101, 2'd2, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 1'b1, 1'b1);
        drive(4'h0, 2'd2, 64'h0, 1'b1, 1'b1);
        drain("partial_reads");
    endtask

    task automatic test_areset();
        swap_hold = 1'b1;
        drive(4'b1000, 2'd3, {16'h1234, 48'h0}, 1'b0, 1'b0);
        check_bit("areset_armed", commit_pending, 1'b1);
        drive(4'h0, 2'd1, 64'h0, 1'b1, 1'b0);
        coeff_in_areset = 1'b1;
        step();
        coeff_in_areset = 1'b0;
        model_clear(1'b0);
        check_bit("areset_pending", commit_pending, 1'b0);
        swap_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_bit("areset_no_done", swap_done, 1'b0);
        end
        check_active("areset_active_kept");
        for (int a = 0; a < 4; a++) drive(4'h0, 2'(a), 64'h0, 1'b1, 1'b1);
        drain("areset_reads");
    endtask

    task automatic test_async_reset();
        drive(4'hF, 2'd1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        drive(4'h0, 2'd1, 64'h0, 1'b1, 1'b1);
        step();
        // The first read has produced its result; the next one is cut by reset.
        drive(4'h0, 2'd1, 64'h0, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (coeff_out_valid !== 4'h0 || coeff_out_data !== 64'h0 || coeffs_active !== 256'h0) begin
            fails++;
            $display("FAIL async_reset: got valid=%h data=%h active_nz=%b, required all 0",
                     coeff_out_valid, coeff_out_data, |coeffs_active);
        end
        check_bit("async_pending", commit_pending, 1'b0);
        model_clear(1'b1);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (5) step();
        drive(4'h0, 2'd1, 64'h0, 1'b1, 1'b1);
        drain("async_recover");
    endtask

    initial begin
        test_reset();
        test_commit();
        test_hold();
        test_partial_rbw();
        test_areset();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
